// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position, data enable and lock status from an incoming hsync/vsync stream
module vga_sync_decoder #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int LOCK_FRAMES = 2,
  localparam int H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW         = $clog2(H_TOTAL),
  localparam int VW         = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_en,
  input  logic          hsync,
  input  logic          vsync,
  output logic          de,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          locked,
  output logic          frame_start,
  output logic          err
);
  // counters are one bit wider when needed so they can saturate at the full total
  localparam int HC = $clog2(H_TOTAL + 1);
  localparam int VC = $clog2(V_TOTAL + 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [HC-1:0] H_MAX   = HC'(H_TOTAL);
  localparam logic [HC-1:0] H_LAST  = HC'(H_TOTAL - 1);
  localparam logic [HC-1:0] H_SLAST = HC'(H_SYNC - 1);
  localparam logic [HC-1:0] H_BEG   = HC'(H_SYNC + H_BACK);
  localparam logic [HC-1:0] H_END   = HC'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [VC-1:0] V_MAX   = VC'(V_TOTAL);
  localparam logic [VC-1:0] V_LAST  = VC'(V_TOTAL - 1);
  localparam logic [VC-1:0] V_SLAST = VC'(V_SYNC - 1);
  localparam logic [VC-1:0] V_BEG   = VC'(V_SYNC + V_BACK);
  localparam logic [VC-1:0] V_END   = VC'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [GW-1:0] G_LAST  = GW'(LOCK_FRAMES - 1);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   good_q, good_d;
  logic [HC-1:0]   hcnt_q, hcnt_d;
  logic [VC-1:0]   vcnt_q, vcnt_d;
  logic            hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic            de_q, de_d, locked_q, locked_d, fs_q, fs_d, err_q, err_d;
  logic [HW-1:0]   x_q, x_d;
  logic [VW-1:0]   y_q, y_d;
  logic            hs_a, vs_a, h_lead, h_trail, v_lead, v_trail, viol;

  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign locked      = locked_q;
  assign frame_start = fs_q;
  assign err         = err_q;

  // edge detection, timing checks, lock FSM and position outputs for the current pixel sample
  always_comb begin
    hs_a      = hsync == HSYNC_POL;
    vs_a      = vsync == VSYNC_POL;
    h_lead    = hs_a && !hs_prev_q;
    h_trail   = !hs_a && hs_prev_q;
    v_lead    = h_lead && vs_a && !vs_prev_q;
    v_trail   = h_lead && !vs_a && vs_prev_q;
    viol      = state_q != SEARCH && (
                  (h_lead && hcnt_q != H_LAST) ||
                  (h_trail && hcnt_q != H_SLAST) ||
                  (!h_lead && hcnt_q == H_LAST) ||
                  (v_lead && vcnt_q != V_LAST) ||
                  (v_trail && vcnt_q != V_SLAST) ||
                  (h_lead && !v_lead && vcnt_q == V_LAST));
    state_d   = state_q;
    good_d    = good_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;
    locked_d  = locked_q;
    de_d      = de_q;
    x_d       = x_q;
    y_d       = y_q;
    fs_d      = 1'b0;
    err_d     = 1'b0;
    if (pix_en) begin
      hs_prev_d = hs_a;
      vs_prev_d = h_lead ? vs_a : vs_prev_q;
      hcnt_d    = h_lead ? '0 : hcnt_q + HC'(hcnt_q != H_MAX);
      vcnt_d    = v_lead ? '0 : vcnt_q + VC'(h_lead && vcnt_q != V_MAX);
      if (viol) begin
        state_d = v_lead ? TRACK : SEARCH;
        good_d  = '0;
      end else if (v_lead) begin
        if (state_q == SEARCH) state_d = TRACK;
        else if (state_q == TRACK && good_q == G_LAST) state_d = LOCKED;
        good_d = state_q == TRACK ? good_q + 1'b1 : '0;
      end
      locked_d = state_d == LOCKED;
      de_d     = locked_d && hcnt_d >= H_BEG && hcnt_d < H_END && vcnt_d >= V_BEG && vcnt_d < V_END;
      x_d      = de_d ? HW'(hcnt_d - H_BEG) : '0;
      y_d      = de_d ? VW'(vcnt_d - V_BEG) : '0;
      fs_d     = v_lead;
      err_d    = viol;
    end
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SEARCH;
      good_q    <= '0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      locked_q  <= 1'b0;
      de_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      good_q    <= good_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      locked_q  <= locked_d;
      de_q      <= de_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed checks of sync decoding, lock acquisition and error recovery on a small video mode
module tb_vga_sync_decoder;
  localparam int HV = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VV = 4, VF = 1, VSW = 2, VB = 2;
  localparam int HT = HV + HF + HSW + HB;
  localparam int VT = VV + VF + VSW + VB;
  localparam bit HP = 1'b0;
  localparam bit VP = 1'b1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pix_en = 1'b0;
  logic hsync = ~HP;
  logic vsync = ~VP;
  logic de, locked, frame_start, err;
  logic [3:0] x;
  logic [3:0] y;

  int checks = 0;
  int errors = 0;

  int err_cnt = 0, fs_cnt = 0, de_cnt = 0, lock_fs = -1;
  int first_x = -1, first_y = -1, first_h = -1, first_v = -1, last_x = -1, last_y = -1;
  int bh = 0, bv = 0;
  bit need_first = 1'b0, locked_prev = 1'b0;
  logic sampled = 1'b0;
  int e0, fe, d0, d1;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .de(de), .x(x), .y(y), .locked(locked), .frame_start(frame_start), .err(err)
  );

  always #5 clk = ~clk;

  // remembers whether the DUT took a pixel sample at the last rising edge
  always @(posedge clk) sampled <= pix_en;

  // event counters observed half a cycle after each edge
  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (frame_start === 1'b1) begin
      fs_cnt++;
      need_first = 1'b1;
    end
    if (locked === 1'b1 && !locked_prev) lock_fs = fs_cnt;
    locked_prev = locked === 1'b1;
    if (sampled && de === 1'b1) begin
      de_cnt++;
      if (need_first) begin
        first_x = int'(x);
        first_y = int'(y);
        first_h = bh;
        first_v = bv;
        need_first = 1'b0;
      end
      last_x = int'(x);
      last_y = int'(y);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one pixel: 3 idle clocks, then one clock with pix_en high; returns after the following falling edge
  task automatic pix(input bit hs_on, input bit vs_on, input int h, input int v);
    repeat (3) @(posedge clk);
    #1;
    hsync  = hs_on ? HP : ~HP;
    vsync  = vs_on ? VP : ~VP;
    bh     = h;
    bv     = v;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic line(input int v, input int len, input int hw, input int from);
    for (int h = from; h < len; h++) pix(h < hw, v < VSW, h, v);
  endtask

  task automatic lines(input int a, input int b);
    for (int v = a; v < b; v++) line(v, HT, HSW, 0);
  endtask

  task automatic frame();
    lines(0, VT);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_de", de, 0);
    chk("reset_x", x, 0);
    chk("reset_y", y, 0);
    chk("reset_locked", locked, 0);
    chk("reset_frame_start", frame_start, 0);
    chk("reset_err", err, 0);
    @(negedge clk);
    reset_n = 1'b1;

    frame();
    frame();
    chk("unlocked_after_2_edges", locked, 0);
    chk("frame_start_count", fs_cnt, 2);
    chk("no_de_while_unlocked", de_cnt, 0);
    d0 = de_cnt;
    frame();
    chk("lock_at_3rd_edge", lock_fs, 3);
    chk("locked_high", locked, 1);
    chk("de_per_frame", de_cnt - d0, HV * VV);
    chk("first_x", first_x, 0);
    chk("first_y", first_y, 0);
    chk("first_hcnt", first_h, HSW + HB);
    chk("first_vcnt", first_v, VSW + VB);
    chk("last_x", last_x, HV - 1);
    chk("last_y", last_y, VV - 1);
    chk("ideal_no_err", err_cnt, 0);

    e0 = err_cnt;
    lines(0, 5);
    line(5, HT - 1, HSW, 0);
    pix(1'b1, 1'b0, 0, 6);
    chk("short_line_err", err, 1);
    chk("short_line_unlock", locked, 0);
    chk("short_line_err_count", err_cnt, e0 + 1);
    fe = fs_cnt;
    d1 = de_cnt;
    line(6, HT, HSW, 1);
    lines(7, VT);
    chk("short_line_de_off", de_cnt, d1);
    frame();
    frame();
    chk("short_line_not_relocked", locked, 0);
    frame();
    chk("short_line_relock_edge", lock_fs, fe + 3);
    chk("short_line_relocked", locked, 1);
    chk("short_line_single_err", err_cnt, e0 + 1);

    e0 = err_cnt;
    lines(0, 3);
    pix(1'b1, 1'b0, 0, 3);
    pix(1'b1, 1'b0, 1, 3);
    pix(1'b0, 1'b0, 2, 3);
    chk("narrow_hsync_err", err, 1);
    chk("narrow_hsync_unlock", locked, 0);
    fe = fs_cnt;
    line(3, HT, 2, 3);
    lines(4, VT);
    frame();
    frame();
    chk("narrow_hsync_not_relocked", locked, 0);
    frame();
    chk("narrow_hsync_relock_edge", lock_fs, fe + 3);
    chk("narrow_hsync_single_err", err_cnt, e0 + 1);

    e0 = err_cnt;
    lines(0, 3);
    pix(1'b0, 1'b0, HT, 2);
    chk("h_timeout_err", err, 1);
    chk("h_timeout_unlock", locked, 0);
    for (int i = 0; i < 40; i++) pix(1'b0, 1'b0, HT + 1 + i, 2);
    chk("h_timeout_once", err_cnt, e0 + 1);
    frame();
    frame();
    frame();
    chk("h_timeout_relocked", locked, 1);

    e0 = err_cnt;
    d0 = de_cnt;
    pix(1'b1, 1'b1, 0, 0);
    chk("frame_start_pulse", frame_start, 1);
    line(0, HT, HSW, 1);
    lines(1, 5);
    line(5, 7, HSW, 0);
    chk("pause_pre_de", de, 1);
    chk("pause_pre_x", x, 1);
    chk("pause_pre_y", y, 1);
    repeat (50) @(posedge clk);
    #1;
    chk("pause_de_hold", de, 1);
    chk("pause_x_hold", x, 1);
    chk("pause_y_hold", y, 1);
    pix(1'b0, 1'b0, 7, 5);
    chk("pause_resume_x", x, 2);
    line(5, HT, HSW, 8);
    lines(6, VT);
    chk("pause_frame_de", de_cnt - d0, HV * VV);
    chk("pause_no_err", err_cnt, e0);
    chk("pause_still_locked", locked, 1);

    lines(0, 5);
    line(5, 7, HSW, 0);
    chk("pre_reset_de", de, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_reset_de", de, 0);
    chk("async_reset_x", x, 0);
    chk("async_reset_y", y, 0);
    chk("async_reset_locked", locked, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    fe = fs_cnt;
    frame();
    frame();
    chk("reset_not_relocked", locked, 0);
    frame();
    chk("reset_relock_edge", lock_fs, fe + 3);
    chk("reset_relocked", locked, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
